// File: rtl/mont_domain_converter.sv
// Bit-serial normal <-> Montgomery domain converter for affine (x, y) pairs, R = 2^SIZE.
// Optional operand/modulus range check is compiled in with `define MONT_CONV_RANGE_CHECK_EN.
module mont_domain_converter #(
  parameter int SIZE = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            start,
  input  logic            mode,
  input  logic [SIZE-1:0] x_in,
  input  logic [SIZE-1:0] y_in,
  input  logic [SIZE-1:0] prime,
  output logic [SIZE-1:0] x_out,
  output logic [SIZE-1:0] y_out,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [SIZE-1:0] r_reg [2];
  logic [SIZE-1:0] r_step [2];
  logic [SIZE-1:0] operand [2];
  logic [SIZE-1:0] p_reg;
  logic            mode_reg;
  logic            capture, step, finish, abort;

  assign operand[0] = x_in;
  assign operand[1] = y_in;

  // One iteration per lane: modular double (to Montgomery) or modular halve (from Montgomery).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [SIZE:0]   dbl;
      logic [SIZE-1:0] dbl_red;
      logic [SIZE-1:0] half;

      assign dbl     = {r_reg[gi], 1'b0};
      // When dbl >= p the reduced value is < p, so the low SIZE bits of the difference are exact.
      assign dbl_red = (dbl >= {1'b0, p_reg}) ? (dbl[SIZE-1:0] - p_reg) : dbl[SIZE-1:0];
      // (r + p) >> 1 without a SIZE+1-bit adder: halve each term and add back the shared low carry.
      assign half    = r_reg[gi][0]
                     ? (r_reg[gi] >> 1) + (p_reg >> 1) + {{(SIZE-1){1'b0}}, p_reg[0]}
                     : (r_reg[gi] >> 1);
      assign r_step[gi] = mode_reg ? half : dbl_red;
    end
  endgenerate

`ifdef MONT_CONV_RANGE_CHECK_EN
  logic bad_reg;
  logic req_bad;
  logic err_reg;

  assign req_bad = (x_in >= prime) || (y_in >= prime) || !prime[0] ||
                   (prime <= SIZE'(1));
  assign abort   = bad_reg;
  assign err     = err_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bad_reg <= 1'b0;
      err_reg <= 1'b0;
    end else if (capture) begin
      bad_reg <= req_bad;
      err_reg <= 1'b0;
    end else if (finish) begin
      err_reg <= bad_reg;
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort || (cnt_reg == CW'(SIZE))) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          step     = 1'b1;
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      r_reg[0]  <= '0;
      r_reg[1]  <= '0;
      p_reg     <= '0;
      mode_reg  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        r_reg[0] <= operand[0];
        r_reg[1] <= operand[1];
        p_reg    <= prime;
        mode_reg <= mode;
      end else if (step) begin
        r_reg[0] <= r_step[0];
        r_reg[1] <= r_step[1];
      end
      // A rejected request reports zeros rather than whatever the working registers hold.
      if (finish) begin
        x_out <= abort ? '0 : r_reg[0];
        y_out <= abort ? '0 : r_reg[1];
      end
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_mont_domain_converter.sv
// Directed bench for mont_domain_converter at SIZE=4 and SIZE=32 with hand-computed results.
module tb_mont_domain_converter;

  logic clk = 1'b0;
  logic rst;

  logic       start4, mode4, busy4, done4, err4;
  logic [3:0] x4, y4, p4, xo4, yo4;

  logic        start32, mode32, busy32, done32, err32;
  logic [31:0] x32, y32, p32, xo32, yo32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mont_domain_converter #(.SIZE(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .start(start4), .mode(mode4),
    .x_in(x4), .y_in(y4), .prime(p4),
    .x_out(xo4), .y_out(yo4), .busy(busy4), .done(done4), .err(err4)
  );

  mont_domain_converter #(.SIZE(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .start(start32), .mode(mode32),
    .x_in(x32), .y_in(y32), .prime(p32),
    .x_out(xo32), .y_out(yo32), .busy(busy32), .done(done32), .err(err32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for the IDLE cycle, issues one request, and counts edges from capture to done.
  task automatic conv(input bit big, input logic m, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] p, output int lat, output int busy_cycles);
    @(posedge clk); #1;
    if (big) begin
      start32 = 1'b1; mode32 = m; x32 = x; y32 = y; p32 = p;
    end else begin
      start4 = 1'b1; mode4 = m; x4 = x[3:0]; y4 = y[3:0]; p4 = p[3:0];
    end
    @(posedge clk); #1;
    start4 = 1'b0; start32 = 1'b0;
    lat = 0; busy_cycles = 0;
    while (!(big ? done32 : done4) && lat < 100) begin
      if (big ? busy32 : busy4) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    if (big)
      $display("conv size=32 mode=%0d x=%0h y=%0h p=%0h -> x_out=%0h y_out=%0h err=%0b lat=%0d",
               m, x, y, p, xo32, yo32, err32, lat);
    else
      $display("conv size=4 mode=%0d x=%0h y=%0h p=%0h -> x_out=%0h y_out=%0h err=%0b lat=%0d",
               m, x[3:0], y[3:0], p[3:0], xo4, yo4, err4, lat);
  endtask

  initial begin
    int lat, bc;
    rst = 1'b1;
    start4 = 0; mode4 = 0; x4 = 0; y4 = 0; p4 = 0;
    start32 = 0; mode32 = 0; x32 = 0; y32 = 0; p32 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_x_out", xo4, 0);
    check("reset_busy", busy4, 0);
    check("reset_done", done4, 0);
    check("reset_err", err4, 0);
    @(negedge clk); rst = 1'b0;

    // Forward: 5*16 mod 13 = 2, 7*16 mod 13 = 8
    conv(0, 1'b0, 5, 7, 13, lat, bc);
    check("fwd_latency", lat, 5);
    check("fwd_busy_cycles", bc, 5);
    check("fwd_busy_in_done", busy4, 1);
    check("fwd_x", xo4, 2);
    check("fwd_y", yo4, 8);
    check("fwd_err", err4, 0);
    @(posedge clk); #1;
    check("done_single_cycle", done4, 0);
    check("idle_busy_low", busy4, 0);
    check("hold_x", xo4, 2);

    // Inverse round trip and boundary operands
    conv(0, 1'b1, 2, 8, 13, lat, bc);
    check("inv_x", xo4, 5);
    check("inv_y", yo4, 7);
    check("inv_latency", lat, 5);
    conv(0, 1'b1, 0, 0, 13, lat, bc);
    check("inv_zero_x", xo4, 0);
    check("inv_zero_y", yo4, 0);
    conv(0, 1'b0, 12, 0, 13, lat, bc);
    check("fwd_max_x", xo4, 10);
    check("fwd_zero_y", yo4, 0);

    // Start during RUN is ignored; outputs hold until the entering-DONE edge
    @(posedge clk); #1;
    start4 = 1; mode4 = 0; x4 = 5; y4 = 7; p4 = 13;
    @(posedge clk); #1;
    start4 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start4 = 1; x4 = 1; y4 = 1; mode4 = 1;
    check("hold_during_run", xo4, 10);
    @(posedge clk); #1;
    start4 = 0;
    lat = 3;
    while (!done4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("ignored-start request -> x_out=%0h y_out=%0h lat=%0d", xo4, yo4, lat);
    check("ignore_latency", lat, 5);
    check("ignore_x", xo4, 2);
    check("ignore_y", yo4, 8);
    conv(0, 1'b1, 2, 8, 13, lat, bc);
    check("after_done_accept_x", xo4, 5);
    check("after_done_accept_y", yo4, 7);

    // Asynchronous reset mid-RUN
    @(posedge clk); #1;
    start4 = 1; mode4 = 0; x4 = 5; y4 = 7; p4 = 13;
    @(posedge clk); #1;
    start4 = 0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    $display("async reset mid-run -> x_out=%0h busy=%0b done=%0b", xo4, busy4, done4);
    check("arst_x", xo4, 0);
    check("arst_y", yo4, 0);
    check("arst_busy", busy4, 0);
    check("arst_done", done4, 0);
    check("arst_err", err4, 0);
    @(negedge clk); rst = 1'b0;
    conv(0, 1'b0, 5, 7, 13, lat, bc);
    check("post_rst_x", xo4, 2);
    check("post_rst_y", yo4, 8);
    check("post_rst_latency", lat, 5);

`ifdef MONT_CONV_RANGE_CHECK_EN
    conv(0, 1'b0, 13, 7, 13, lat, bc);
    check("rc_latency", lat, 1);
    check("rc_err", err4, 1);
    check("rc_x", xo4, 0);
    check("rc_y", yo4, 0);
    conv(0, 1'b0, 5, 7, 13, lat, bc);
    check("rc_clear_err", err4, 0);
    check("rc_valid_x", xo4, 2);
    conv(0, 1'b0, 5, 7, 12, lat, bc);
    check("rc_even_prime_err", err4, 1);
    check("rc_even_prime_x", xo4, 0);
`else
    conv(0, 1'b0, 13, 7, 13, lat, bc);
    check("norc_latency", lat, 5);
    check("norc_err", err4, 0);
`endif

    // SIZE=32: 2^32 mod (2^32 - 5) = 5
    conv(1, 1'b0, 1, 0, 32'hFFFF_FFFB, lat, bc);
    check("w32_fwd_x", xo32, 5);
    check("w32_fwd_y", yo32, 0);
    check("w32_latency", lat, 33);
    conv(1, 1'b1, 5, 0, 32'hFFFF_FFFB, lat, bc);
    check("w32_inv_x", xo32, 1);
    check("w32_err", err32, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mont_domain_converter.md
Name: mont_domain_converter

Overview:
- Converts affine coordinates between the normal and Montgomery domains for the ECC scalar-multiplication datapath.
- It is the stage directly upstream of the control FSM: it supplies Px_mont/Py_mont from raw Px/Py.
- The same block converts kP results back out of the Montgomery domain.
- Bit-serial: one modular double (forward) or one modular halve (inverse) per clock, on x and y in parallel, modulo prime with R = 2^SIZE.

Parameters:
- SIZE, 32, operand width in bits; R = 2^SIZE; iteration count = SIZE.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = to Montgomery (v*R mod p); 1 = from Montgomery (v*R^-1 mod p); captured with start.
- x_in  input  SIZE  x operand; captured with start.
- y_in  input  SIZE  y operand; captured with start.
- prime  input  SIZE  modulus p; captured with start. Odd and > 1; operands < p.
- x_out  output  SIZE  converted x; registered; held until next accepted start.
- y_out  output  SIZE  converted y; registered; held until next accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle completion pulse.
- err  output  1  range-check failure flag; only driven when the optional feature is enabled, else tied 0.

Behaviour:
- Reset (async, immediate) forces state IDLE, counter 0, and all of x_out, y_out, busy, done, err to 0, including mid-conversion. No partial result survives reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge captures x_in, y_in, prime and mode into working registers rx, ry, rp, rm; clears counter; moves to RUN.
  - start=0 stays in IDLE.
- RUN: each edge applies one iteration to rx and ry independently, then counter += 1. After the SIZE-th iteration edge, moves to DONE.
  - mode 0: t = {r,1'b0} (SIZE+1 bits); r = (t >= p) ? t - p : t.
  - mode 1: t = r[0] ? r + p : r (SIZE+1 bits, carry kept); r = t >> 1.
- Intermediates are SIZE+1 bits wide so there is no overflow at SIZE=32. Results are always < p when the inputs are < p.
- DONE: x_out/y_out are loaded with rx/ry on the edge entering DONE. done=1 for exactly this one cycle, then the block returns to IDLE.
- Latency: done is high in the cycle starting SIZE+1 edges after the start-capture edge. The next start is accepted in IDLE, i.e. one cycle after done.
- start while busy (RUN or DONE) is ignored and not queued. Input changes during RUN have no effect.
- x_out/y_out change only on the edge entering DONE.
- Operand 0 gives 0 in both modes.

Optional Feature:
- Macro: MONT_CONV_RANGE_CHECK_EN.
- Enabled: on an accepted start, if x_in >= prime, y_in >= prime, prime[0] == 0, or prime <= 1, the block skips RUN and goes straight to DONE on the next edge. It sets x_out = y_out = 0, err = 1, and pulses done there. err holds until the next accepted start (cleared at capture) or reset. A valid request completes normally with err = 0.
- Disabled: no checks; err is constant 0; out-of-range inputs give an unspecified but deterministic result with normal latency.

Test Plan:
- SIZE=4, p=13, mode 0, x=5, y=7: start -> done exactly 5 edges after capture; x_out=2, y_out=8; busy high for 5 cycles.
- SIZE=4, p=13, mode 1, x=2, y=8: start -> x_out=5, y_out=7 (round trip); also x=0 -> 0, and mode 0 x=12 -> 10.
- SIZE=4, p=13: pulse start again in the 3rd RUN cycle with x=1 -> ignored; outputs are from the first request; a start issued 1 cycle after done is accepted.
- SIZE=4: assert i_rst asynchronously mid-RUN -> outputs, busy, done and err are 0 immediately; the next start (x=5, y=7, p=13, mode 0) completes correctly with 2/8.
- MONT_CONV_RANGE_CHECK_EN defined, SIZE=4, p=13, x=13 -> done one edge after capture, err=1, x_out=y_out=0. Then a valid request clears err. p=12 -> err=1.
- SIZE=32, p=0xFFFFFFFB, mode 0, x=1 -> x_out=5 (2^32 mod p). Mode 1 on 5 -> 1. Latency 33 edges.
